// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, aluop encodings and R-type funct values shared by the issue stage
package alu_pkg;
  localparam logic [3:0] CTL_AND  = 4'd0;
  localparam logic [3:0] CTL_OR   = 4'd1;
  localparam logic [3:0] CTL_ADD  = 4'd2;
  localparam logic [3:0] CTL_SLTU = 4'd3;
  localparam logic [3:0] CTL_SUB  = 4'd6;
  localparam logic [3:0] CTL_SLT  = 4'd7;
  localparam logic [3:0] CTL_NOR  = 4'd12;
  localparam logic [3:0] CTL_ILL  = 4'd15;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational aluop+funct to 4-bit ALU control, flags unknown funct as illegal
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctl_o,
  output logic       illegal_o
);
  logic [3:0] fctl;
  always_comb begin
    fctl = CTL_ILL;
    case (funct_i)
      FUNCT_AND:  fctl = CTL_AND;
      FUNCT_OR:   fctl = CTL_OR;
      FUNCT_ADD:  fctl = CTL_ADD;
      FUNCT_SUB:  fctl = CTL_SUB;
      FUNCT_SLT:  fctl = CTL_SLT;
      FUNCT_SLTU: fctl = CTL_SLTU;
      FUNCT_NOR:  fctl = CTL_NOR;
      default:    fctl = CTL_ILL;
    endcase
    ctl_o = aluop_i == ALUOP_FUNCT ? fctl :
            aluop_i == ALUOP_SUB   ? CTL_SUB :
            aluop_i == ALUOP_OR    ? CTL_OR  : CTL_ADD;
    illegal_o = aluop_i == ALUOP_FUNCT && fctl == CTL_ILL;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage with 2-entry skid buffer feeding the ALU.
// Define ALU_ISSUE_FWD_EN to add the fwd_* writeback bypass applied at capture.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_funct,
  input  logic [DWIDTH-1:0] in_rs_data,
  input  logic [DWIDTH-1:0] in_rt_data,
  input  logic [DWIDTH-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [RWIDTH-1:0] in_rs,
  input  logic [RWIDTH-1:0] in_rt,
  input  logic [RWIDTH-1:0] in_rd,
`ifdef ALU_ISSUE_FWD_EN
  input  logic              fwd_valid,
  input  logic [RWIDTH-1:0] fwd_rd,
  input  logic [DWIDTH-1:0] fwd_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_A,
  output logic [DWIDTH-1:0] out_B,
  output logic [3:0]        out_ctl,
  output logic [RWIDTH-1:0] out_rd,
  output logic              out_illegal,
  output logic [31:0]       stall_cnt
);
  typedef struct packed {
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [3:0]        ctl;
    logic [RWIDTH-1:0] rd;
    logic              ill;
  } entry_t;
  entry_t     main_q, skid_q, new_e;
  logic       main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [31:0] stall_q, stall_d;
  logic       main_free, acc;
  logic [3:0] dec_ctl;
  logic       dec_ill;
  alu_ctl_decode u_dec (
    .aluop_i   (in_aluop),
    .funct_i   (in_funct),
    .ctl_o     (dec_ctl),
    .illegal_o (dec_ill)
  );
`ifdef ALU_ISSUE_FWD_EN
  logic fwd_a, fwd_b;
  assign fwd_a = fwd_valid && fwd_rd != '0 && fwd_rd == in_rs;
  assign fwd_b = fwd_valid && fwd_rd != '0 && fwd_rd == in_rt && !in_use_imm;
  assign new_e.a = fwd_a ? fwd_data : in_rs_data;
  assign new_e.b = fwd_b ? fwd_data : in_use_imm ? in_imm : in_rt_data;
`else
  logic unused_idx;
  assign unused_idx = ^{in_rs, in_rt};
  assign new_e.a = in_rs_data;
  assign new_e.b = in_use_imm ? in_imm : in_rt_data;
`endif
  assign new_e.ctl = dec_ctl;
  assign new_e.rd  = in_rd;
  assign new_e.ill = dec_ill;
  assign in_ready  = !skid_v_q;
  assign acc       = in_valid && in_ready;
  assign main_free = !main_v_q || out_ready;
  // a free main slot takes the skid entry first so order is preserved
  always_comb begin
    main_v_d = flush ? 1'b0 : main_free ? (skid_v_q || acc) : 1'b1;
    skid_v_d = flush ? 1'b0 : main_free ? 1'b0 : (skid_v_q || acc);
    stall_d  = (main_v_q && !out_ready && ~&stall_q) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      stall_q  <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      stall_q  <= stall_d;
      if (main_free && skid_v_q) main_q <= skid_q;
      else if (main_free && acc) main_q <= new_e;
      if (!main_free && acc) skid_q <= new_e;
    end
  end
  assign out_valid   = main_v_q;
  assign out_A       = main_q.a;
  assign out_B       = main_q.b;
  assign out_ctl     = main_q.ctl;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.ill;
  assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_use_imm = 1'b0, out_valid, out_ready = 1'b1, out_illegal;
  logic [1:0]  in_aluop = '0;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_rs_data = '0, in_rt_data = '0, in_imm = '0, out_A, out_B, stall_cnt;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, out_rd;
  logic [3:0]  out_ctl;
`ifdef ALU_ISSUE_FWD_EN
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_data = '0;
`endif
  int passed = 0, total = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
    .out_ctl(out_ctl), .out_rd(out_rd), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] rt_d, input logic [4:0] rd);
    in_valid = v; in_aluop = op; in_funct = fn; in_rs_data = a; in_rt_data = rt_d; in_rd = rd;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else passed++;
    total++; if ({out_A, out_B, out_ctl, out_rd, out_illegal} !== '0) $display("FAIL reset outputs got %h %h %h %h %b want 0", out_A, out_B, out_ctl, out_rd, out_illegal); else passed++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL reset stall_cnt got %0d want 0", stall_cnt); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_nor;
    @(negedge clk); drive(1, 2'b10, 6'b100111, 32'd0, 32'd0, 5'd9);
    tick;
    total++; if (out_valid !== 1'b1 || out_ctl !== 4'd12 || out_illegal !== 1'b0 || out_rd !== 5'd9)
      $display("FAIL nor got v=%b ctl=%0d ill=%b rd=%0d want v=1 ctl=12 ill=0 rd=9", out_valid, out_ctl, out_illegal, out_rd); else passed++;
    @(negedge clk); in_valid = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0) $display("FAIL nor_drain out_valid got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_decode;
    logic [1:0] ops [10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] fns [10] = '{6'h3f, 6'h00, 6'h24, 6'h24, 6'h25, 6'h20, 6'h22, 6'h2a, 6'h2b, 6'h3f};
    logic [3:0] ctl [10] = '{4'd2, 4'd6, 4'd1, 4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd15};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(1, ops[i], fns[i], 32'h1000 + i, 32'd0, 5'(i));
      tick;
      total++; if (out_valid !== 1'b1 || out_ctl !== ctl[i] || out_illegal !== (i == 9) || out_A !== 32'h1000 + i)
        $display("FAIL decode[%0d] got v=%b ctl=%0d ill=%b A=%h want v=1 ctl=%0d ill=%b A=%h",
                 i, out_valid, out_ctl, out_illegal, out_A, ctl[i], i == 9, 32'h1000 + i); else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
    tick;
  endtask

  task automatic test_imm;
    @(negedge clk); drive(1, 2'b00, 6'd0, 32'd1, 32'd5, 5'd1); in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFF;
    tick;
    total++; if (out_B !== 32'hFFFF_FFFF) $display("FAIL imm out_B got %h want ffffffff", out_B); else passed++;
    @(negedge clk); in_use_imm = 1'b0;
    tick;
    total++; if (out_B !== 32'd5) $display("FAIL rt out_B got %h want 5", out_B); else passed++;
    @(negedge clk); in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    @(negedge clk); out_ready = 1'b0; drive(1, 2'b00, 6'd0, 32'h100, 32'd0, 5'd1);
    tick;
    total++; if (out_A !== 32'h100 || in_ready !== 1'b1 || stall_cnt !== 32'd0)
      $display("FAIL skid_i0 got A=%h rdy=%b stall=%0d want A=100 rdy=1 stall=0", out_A, in_ready, stall_cnt); else passed++;
    @(negedge clk); drive(1, 2'b00, 6'd0, 32'h200, 32'd0, 5'd2);
    tick;
    total++; if (out_A !== 32'h100 || in_ready !== 1'b0 || stall_cnt !== 32'd1)
      $display("FAIL skid_full got A=%h rdy=%b stall=%0d want A=100 rdy=0 stall=1", out_A, in_ready, stall_cnt); else passed++;
    @(negedge clk); drive(1, 2'b00, 6'd0, 32'h300, 32'd0, 5'd3);
    tick;
    total++; if (out_A !== 32'h100 || out_rd !== 5'd1 || stall_cnt !== 32'd2)
      $display("FAIL skid_hold got A=%h rd=%0d stall=%0d want A=100 rd=1 stall=2", out_A, out_rd, stall_cnt); else passed++;
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    tick;
    total++; if (out_valid !== 1'b1 || out_A !== 32'h200 || in_ready !== 1'b1 || stall_cnt !== 32'd2)
      $display("FAIL skid_i1 got v=%b A=%h rdy=%b stall=%0d want v=1 A=200 rdy=1 stall=2", out_valid, out_A, in_ready, stall_cnt); else passed++;
    tick;
    total++; if (out_valid !== 1'b0 || stall_cnt !== 32'd2)
      $display("FAIL skid_empty got v=%b stall=%0d want v=0 stall=2", out_valid, stall_cnt); else passed++;
  endtask

  task automatic test_flush;
    @(negedge clk); out_ready = 1'b0; drive(1, 2'b00, 6'd0, 32'h111, 32'd0, 5'd4);
    @(negedge clk); drive(1, 2'b00, 6'd0, 32'h222, 32'd0, 5'd5);
    @(negedge clk); drive(1, 2'b00, 6'd0, 32'h400, 32'd0, 5'd6); flush = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else passed++;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0 || stall_cnt !== 32'd4)
      $display("FAIL post_flush got v=%b stall=%0d want v=0 stall=4", out_valid, stall_cnt); else passed++;
  endtask

`ifdef ALU_ISSUE_FWD_EN
  task automatic test_fwd;
    @(negedge clk); drive(1, 2'b00, 6'd0, 32'h1, 32'h2, 5'd7); in_rs = 5'd3; in_rt = 5'd3;
    fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hA5;
    tick;
    total++; if (out_A !== 32'hA5 || out_B !== 32'hA5) $display("FAIL fwd got A=%h B=%h want a5 a5", out_A, out_B); else passed++;
    @(negedge clk); fwd_rd = 5'd0; in_rs = 5'd0; in_rt = 5'd0;
    tick;
    total++; if (out_A !== 32'h1 || out_B !== 32'h2) $display("FAIL fwd_r0 got A=%h B=%h want 1 2", out_A, out_B); else passed++;
    @(negedge clk); in_valid = 1'b0; fwd_valid = 1'b0;
    tick;
  endtask
`endif

  task automatic test_rst_mid;
    @(negedge clk); out_ready = 1'b0; drive(1, 2'b01, 6'd0, 32'h55, 32'd0, 5'd8);
    tick;
    total++; if (out_valid !== 1'b1 || out_ctl !== 4'd6) $display("FAIL pre_rst got v=%b ctl=%0d want v=1 ctl=6", out_valid, out_ctl); else passed++;
    #2 rst = 1'b1; #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 32'd0)
      $display("FAIL rst_mid got v=%b rdy=%b stall=%0d want v=0 rdy=1 stall=0", out_valid, in_ready, stall_cnt); else passed++;
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_nor;
    test_decode;
    test_imm;
    test_back_to_back;
    test_flush;
`ifdef ALU_ISSUE_FWD_EN
    test_fwd;
`endif
    test_rst_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
